// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: sequencer between a host command port and the CPU core pins.
// Host commands are buffered in a FIFO. On start they are issued to the CPU one at a time,
// each followed by a NOP. Then every readout slot is scanned and its value/sign is returned
// to the host.
// Optional feature: define SEQ_ABORT_EN to add abort_i, which flushes and returns to idle.

module cpu_seq_ctrl #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 5,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       VOUT_N     = 4,
  parameter int unsigned       SETTLE_CYC = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR  = '0
) (
  input  logic              clk_i,
  input  logic              resetn,
  // host command port
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_instr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_dor_i,
  input  logic              start_i,
`ifdef SEQ_ABORT_EN
  input  logic              abort_i,
`endif
  // CPU core side
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              dor_o,
  output logic [1:0]        vout_addr_o,
  input  logic [DATA_W-1:0] value_i,
  input  logic              is_pos_i,
  // host readout port
  output logic              rd_valid_o,
  output logic [1:0]        rd_idx_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_pos_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned CmdW   = DATA_W + ADDR_W + 1;

  localparam logic [CntW-1:0]   SettleLoad = CntW'(SETTLE_CYC);
  localparam logic [CountW-1:0] FullCount  = CountW'(FIFO_DEPTH);
  localparam logic [1:0]        LastSlot   = 2'(VOUT_N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StScan,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Command FIFO
  logic [CmdW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;

  // Shared settle/scan hold counter
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Registered outputs
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dor_q, dor_d;
  logic [1:0]        vout_q, vout_d;
  logic              rd_valid_q, rd_valid_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_pos_q, rd_pos_d;
  logic              done_q, done_d;

  assign fifo_full   = (count_q == FullCount);
  assign fifo_empty  = (count_q == '0);
  assign cmd_ready_o = (state_q == StIdle) && !fifo_full;
  // Pushes only happen in idle, pops only in issue, so they never coincide.
  assign push        = cmd_valid_i && cmd_ready_o;

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_instr_i, cmd_addr_i, cmd_dor_i};
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    dor_d      = dor_q;
    vout_d     = vout_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;
    rd_pos_d   = rd_pos_q;
    done_d     = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d  = count_q + CountW'(1);
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = SettleLoad;
        if (!fifo_empty) begin
          {instr_d, addr_d, dor_d} = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          count_d  = count_q - CountW'(1);
          state_d  = StSettle;
        end else begin
          vout_d  = 2'd0;
          state_d = StScan;
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(1)) begin
          // address/dor stay put through the NOP so the core sees a clean gap
          instr_d = NOP_INSTR;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StScan: begin
        // Slot is held SETTLE_CYC+1 cycles: cnt counts SETTLE_CYC down to 0
        if (cnt_q == '0) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = vout_q;
          rd_data_d  = value_i;
          rd_pos_d   = is_pos_i;
          if (vout_q == LastSlot) begin
            state_d = StDone;
          end else begin
            vout_d = vout_q + 2'd1;
            cnt_d  = SettleLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        vout_d  = 2'd0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef SEQ_ABORT_EN
    // Abort overrides everything decided above for this cycle
    if (abort_i && (state_q != StIdle)) begin
      state_d    = StIdle;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      instr_d    = NOP_INSTR;
      vout_d     = 2'd0;
      rd_valid_d = 1'b0;
      rd_idx_d   = rd_idx_q;
      rd_data_d  = rd_data_q;
      rd_pos_d   = rd_pos_q;
      done_d     = 1'b0;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      instr_q    <= NOP_INSTR;
      addr_q     <= '0;
      dor_q      <= 1'b0;
      vout_q     <= 2'd0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= 2'd0;
      rd_data_q  <= '0;
      rd_pos_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      dor_q      <= dor_d;
      vout_q     <= vout_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
      rd_pos_q   <= rd_pos_d;
      done_q     <= done_d;
    end
  end

  assign instr_o     = instr_q;
  assign address_o   = addr_q;
  assign dor_o       = dor_q;
  assign vout_addr_o = vout_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_idx_o    = rd_idx_q;
  assign rd_data_o   = rd_data_q;
  assign rd_pos_o    = rd_pos_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl (default parameters). Expected timing is computed from
// the sequencing rules: each command occupies SETTLE_CYC+1 cycles, each slot SETTLE_CYC+1
// cycles, with the first instruction two cycles after start.

module tb_cpu_seq_ctrl;

  localparam int         S   = 1;
  localparam int         P   = S + 1;
  localparam int         VN  = 4;
  localparam logic [7:0] NOP = 8'h00;

  typedef struct {
    logic [7:0] instr;
    logic [4:0] addr;
    logic       dor;
  } cmd_t;

  typedef struct {
    logic [7:0] instr;
    logic [4:0] addr;
    logic       dor;
    int         exp_cycle;
    logic [7:0] exp_instr;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_instr = '0;
  logic [4:0] cmd_addr = '0;
  logic       cmd_dor = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] instr;
  logic [4:0] address;
  logic       dor;
  logic [1:0] vout_addr;
  logic [7:0] value = '0;
  logic       is_pos = 1'b0;
  logic       rd_valid;
  logic [1:0] rd_idx;
  logic [7:0] rd_data;
  logic       rd_pos;
  logic       busy;
  logic       done;

  int         checks = 0;
  int         errors = 0;
  int         rv_cnt;
  int         done_cnt;
  cmd_t       model_q[$];
  logic [7:0] trace [0:127];
  logic [7:0] val [0:127];
  logic       posv [0:127];
  vec_t       tbl [3];

  always #5 clk = ~clk;

  cpu_seq_ctrl dut (
    .clk_i       (clk),
    .resetn      (resetn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_instr_i (cmd_instr),
    .cmd_addr_i  (cmd_addr),
    .cmd_dor_i   (cmd_dor),
    .start_i     (start),
`ifdef SEQ_ABORT_EN
    .abort_i     (abort),
`endif
    .instr_o     (instr),
    .address_o   (address),
    .dor_o       (dor),
    .vout_addr_o (vout_addr),
    .value_i     (value),
    .is_pos_i    (is_pos),
    .rd_valid_o  (rd_valid),
    .rd_idx_o    (rd_idx),
    .rd_data_o   (rd_data),
    .rd_pos_o    (rd_pos),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".instr"}, 32'(instr), 32'(NOP));
    chk({tag, ".address"}, 32'(address), 32'd0);
    chk({tag, ".dor"}, 32'(dor), 32'd0);
    chk({tag, ".vout"}, 32'(vout_addr), 32'd0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".rd_idx"}, 32'(rd_idx), 32'd0);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, ".rd_pos"}, 32'(rd_pos), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic push_cmd(input logic [7:0] i, input logic [4:0] a, input logic d);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_instr = i;
    cmd_addr  = a;
    cmd_dor   = d;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, required 1", w);
    end else begin
      model_q.push_back('{i, a, d});
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drive_val(input int k, input bit rnd, input logic [7:0] fval);
    val[k]  = rnd ? 8'($urandom) : fval;
    posv[k] = rnd ? 1'($urandom) : fval[7];
    value   = val[k];
    is_pos  = posv[k];
  endtask

  // Starts a run and checks every cycle against timing derived from the queued commands.
  task automatic run_check(input bit push_with_start, input logic [7:0] pi,
                           input logic [4:0] pa, input logic pd,
                           input bit rnd, input logic [7:0] fval);
    cmd_t       cq[$];
    int         n, base, e, i, r, j;
    logic [7:0] ei;
    bit         ev;
    if (push_with_start) model_q.push_back('{pi, pa, pd});
    cq = model_q;
    model_q.delete();
    n    = cq.size();
    base = 2 + n * P;
    e    = base + VN * P;
    rv_cnt   = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    if (push_with_start) begin
      cmd_valid = 1'b1;
      cmd_instr = pi;
      cmd_addr  = pa;
      cmd_dor   = pd;
    end
    drive_val(0, rnd, fval);
    for (int k = 1; k <= e + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (push_with_start) cmd_valid = 1'b0;
      trace[k] = instr;
      if (rd_valid) rv_cnt++;
      if (done) done_cnt++;
      chk($sformatf("busy@%0d", k), 32'(busy), 32'(k <= e));
      chk($sformatf("ready@%0d", k), 32'(cmd_ready), 32'(k > e));
      ei = NOP;
      if (k >= 2 && k <= 1 + n * P) begin
        i = (k - 2) / P;
        r = (k - 2) % P;
        if (r < S) ei = cq[i].instr;
        chk($sformatf("address@%0d", k), 32'(address), 32'(cq[i].addr));
        chk($sformatf("dor@%0d", k), 32'(dor), 32'(cq[i].dor));
      end
      chk($sformatf("instr@%0d", k), 32'(instr), 32'(ei));
      if (k >= base && k < e) j = (k - base) / P;
      else if (k == e) j = VN - 1;
      else j = 0;
      chk($sformatf("vout@%0d", k), 32'(vout_addr), 32'(j));
      ev = (k >= base + P) && (k <= e) && ((k - base) % P == 0);
      chk($sformatf("rd_valid@%0d", k), 32'(rd_valid), 32'(ev));
      if (ev) begin
        chk($sformatf("rd_idx@%0d", k), 32'(rd_idx), 32'((k - base) / P - 1));
        chk($sformatf("rd_data@%0d", k), 32'(rd_data), 32'(val[k-1]));
        chk($sformatf("rd_pos@%0d", k), 32'(rd_pos), 32'(posv[k-1]));
      end
      chk($sformatf("done@%0d", k), 32'(done), 32'(k == e + 1));
      drive_val(k, rnd, fval);
    end
  endtask

  initial begin
    int n;
    int w;
    bit ws;
    tbl[0] = '{8'h11, 5'd1, 1'b0, 2, 8'h11};
    tbl[1] = '{8'h22, 5'd2, 1'b1, 4, 8'h22};
    tbl[2] = '{8'h33, 5'd3, 1'b0, 6, 8'h33};

    // Reset values
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Three commands, table-driven
    for (int t = 0; t < 3; t++) push_cmd(tbl[t].instr, tbl[t].addr, tbl[t].dor);
    run_check(1'b0, '0, '0, 1'b0, 1'b1, '0);
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("tbl%0d.instr", t), 32'(trace[tbl[t].exp_cycle]), 32'(tbl[t].exp_instr));
      chk($sformatf("tbl%0d.nop", t), 32'(trace[tbl[t].exp_cycle + 1]), 32'(NOP));
    end
    chk("tbl.rd_valid_count", 32'(rv_cnt), 32'd4);
    chk("tbl.done_count", 32'(done_cnt), 32'd1);

    // Fill FIFO, hold a ninth command through the whole run
    for (int t = 0; t < 8; t++) push_cmd(8'(8'h40 + t), 5'(t), 1'(t));
    chk("full.ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_instr = 8'h99;
    cmd_addr  = 5'd9;
    cmd_dor   = 1'b1;
    run_check(1'b0, '0, '0, 1'b0, 1'b1, '0);
    cmd_valid = 1'b0;
    model_q.push_back('{8'h99, 5'd9, 1'b1});
    run_check(1'b0, '0, '0, 1'b0, 1'b1, '0);
    chk("held_cmd.instr", 32'(trace[2]), 32'h99);

    // Empty FIFO, constant readout value
    run_check(1'b0, '0, '0, 1'b0, 1'b0, 8'h80);
    chk("empty.rd_valid_count", 32'(rv_cnt), 32'd4);

    // Reset during settle of the second command
    push_cmd(8'hA1, 5'd4, 1'b1);
    push_cmd(8'hA2, 5'd5, 1'b0);
    push_cmd(8'hA3, 5'd6, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset.pre_instr", 32'(instr), 32'hA2);
    resetn = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    resetn = 1'b1;
    model_q.delete();
    run_check(1'b0, '0, '0, 1'b0, 1'b1, '0);

`ifdef SEQ_ABORT_EN
    // Abort during scan of slot 1
    push_cmd(8'hB1, 5'd7, 1'b0);
    push_cmd(8'hB2, 5'd8, 1'b1);
    model_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(busy && vout_addr == 2'd1) && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("abort.reach_slot1", 32'(w < 40), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.instr", 32'(instr), 32'(NOP));
    chk("abort.vout", 32'(vout_addr), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("abort.done@%0d", k), 32'(done), 32'd0);
      chk($sformatf("abort.rd_valid@%0d", k), 32'(rd_valid), 32'd0);
    end
    run_check(1'b0, '0, '0, 1'b0, 1'b1, '0);
`endif

    // Randomized runs, sometimes pushing in the start cycle
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 8);
      for (int t = 0; t < n; t++) push_cmd(8'($urandom), 5'($urandom), 1'($urandom));
      ws = (n < 8) ? 1'($urandom) : 1'b0;
      run_check(ws, 8'($urandom), 5'($urandom), 1'($urandom), 1'b1, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
